// File: rtl/qmem_pkg.sv
// qmem_pkg
//   Shared constants and helpers for the QMEM interconnect blocks.
//   PRIO_RR / PRIO_FIXED select the arbitration mode of qmem_arbiter_rr.
//   QAW_DEF / QDW_DEF are the address/data widths shared with the decoder.
//   onehot2idx converts a one-hot vector (up to MN_MAX bits) to an index.
package qmem_pkg;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    localparam int QAW_DEF = 22;
    localparam int QDW_DEF = 32;

    localparam int MN_MAX = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // An all-zero vector maps to index 0; callers gate on the vector itself.
    function automatic int onehot2idx(input logic [MN_MAX-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MN_MAX; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/qmem_rr_pick.sv
// qmem_rr_pick
//   Combinational rotating-priority picker.
//   req : per-master request vector
//   ptr : index where the search starts; wraps modulo MN
//   gnt : one-hot grant, all zero when no request is pending
module qmem_rr_pick
    import qmem_pkg::*;
#(
    parameter  int MN = 2,
    localparam int PW = $clog2(MN)
)(
    input  logic [MN-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [MN-1:0] gnt
);

    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic          found;
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < MN; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(MN)) begin
                sum = sum - (PW+1)'(MN);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qmem_arbiter_rr.sv
// qmem_arbiter_rr
//   N-master to 1-slave QMEM arbiter, zero added latency.
//   Round-robin or fixed priority, lock held until the slave responds,
//   per-transaction timeout returning an error to the stalled master.
//
//   clk, rst            clock, synchronous active-high reset
//   qm_cs/we/sel/adr/dat_w   packed master requests (master 0 in LSBs)
//   qm_dat_r            slave read data replicated to every master
//   qm_ack/qm_err       per-master response, only ever to the owner
//   qs_*                slave-side request / response
//   ms                  one-hot current owner, zero when idle
//   tmo_evt             one-cycle pulse when the watchdog fires
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | no lock; owner picked combinationally from qm_cs
//   ARB_BUSY | locked on owner_q until qs_ack/qs_err or timeout
module qmem_arbiter_rr
    import qmem_pkg::*;
#(
    parameter int QAW  = QAW_DEF,
    parameter int QDW  = QDW_DEF,
    parameter int QSW  = QDW/8,
    parameter int MN   = 2,
    parameter int PRIO = PRIO_RR,
    parameter int TMO  = 255
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [MN-1:0]     qm_cs,
    input  logic [MN-1:0]     qm_we,
    input  logic [MN*QSW-1:0] qm_sel,
    input  logic [MN*QAW-1:0] qm_adr,
    input  logic [MN*QDW-1:0] qm_dat_w,
    output logic [MN*QDW-1:0] qm_dat_r,
    output logic [MN-1:0]     qm_ack,
    output logic [MN-1:0]     qm_err,
    output logic              qs_cs,
    output logic              qs_we,
    output logic [QSW-1:0]    qs_sel,
    output logic [QAW-1:0]    qs_adr,
    output logic [QDW-1:0]    qs_dat_w,
    input  logic [QDW-1:0]    qs_dat_r,
    input  logic              qs_ack,
    input  logic              qs_err,
    output logic [MN-1:0]     ms,
    output logic              tmo_evt
);

    localparam int          PW      = $clog2(MN);
    localparam logic [15:0] TMO_V   = 16'(TMO);
    // With the watchdog disabled the counter still saturates rather than wraps.
    localparam logic [15:0] CNT_MAX = (TMO == 0) ? 16'hFFFF : TMO_V;
    localparam bit          TMO_EN  = (TMO != 0);

    arb_state_t    state_q, state_d;
    logic [MN-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [15:0]   cnt_q, cnt_d;

    logic [MN-1:0] gnt;
    logic [MN-1:0] sel;
    logic [PW-1:0] pick_ptr;
    logic [PW-1:0] sel_idx;
    logic [PW-1:0] ptr_adv;
    logic          req_live;
    logic          resp;
    logic          done;
    logic          tmo_hit;

    assign pick_ptr = (PRIO == PRIO_FIXED) ? '0 : ptr_q;

    qmem_rr_pick #(.MN(MN)) u_pick (
        .req (qm_cs),
        .ptr (pick_ptr),
        .gnt (gnt)
    );

    always_comb begin
        logic [MN_MAX-1:0] sel_ext;
        sel      = (state_q == ARB_BUSY) ? owner_q : gnt;
        sel_ext  = '0;
        sel_ext[MN-1:0] = sel;
        sel_idx  = PW'(onehot2idx(sel_ext));
        // The just-served master drops to lowest priority.
        ptr_adv  = (sel_idx == PW'(MN-1)) ? '0 : sel_idx + PW'(1);
        req_live = (state_q == ARB_BUSY) || (|gnt);
        resp     = qs_ack || qs_err;
        done     = req_live && resp;
        // A response in the same cycle beats the watchdog.
        tmo_hit  = TMO_EN && (state_q == ARB_BUSY) && (cnt_q == TMO_V) && !resp;
    end

    // Request fields follow the selected master; frozen on owner while locked.
    assign qs_we    = qm_we[sel_idx];
    assign qs_sel   = qm_sel[sel_idx*QSW +: QSW];
    assign qs_adr   = qm_adr[sel_idx*QAW +: QAW];
    assign qs_dat_w = qm_dat_w[sel_idx*QDW +: QDW];
    assign qm_dat_r = {MN{qs_dat_r}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (req_live) begin
                    if (resp) begin
                        ptr_d = ptr_adv;
                    end else begin
                        state_d = ARB_BUSY;
                        owner_d = gnt;
                        cnt_d   = 16'd1;
                    end
                end
            end
            ARB_BUSY: begin
                if (resp || tmo_hit) begin
                    state_d = ARB_IDLE;
                    owner_d = '0;
                    ptr_d   = ptr_adv;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        qs_cs   = req_live && !tmo_hit && !rst;
        ms      = rst ? '0 : sel;
        qm_ack  = (!rst && done && qs_ack) ? sel : '0;
        qm_err  = (!rst && ((done && qs_err) || tmo_hit)) ? sel : '0;
        tmo_evt = !rst && tmo_hit;
    end

endmodule
